// File: rtl/ads5404_pkg.sv
// Shared types and helpers for the ADS5404 sync-alignment block.
package ads5404_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

  localparam int CNT_W_DEF = 16;

  // Adds b to a and clamps the result at max.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/ads5404_lane_align.sv
// Two-lane phase mux: emits {later, earlier} starting on lane 0 (phase 0) or lane 1 (phase 1).
module ads5404_lane_align #(
  parameter int W = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           phase,
  input  logic [W-1:0]   x0,
  input  logic [W-1:0]   x1,
  output logic [2*W-1:0] y
);

  logic [W-1:0] r0;
  logic [W-1:0] r1;

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0 <= '0;
      r1 <= '0;
      y  <= '0;
    end else begin
      r0 <= x0;
      r1 <= x1;
      y  <= phase ? {x0, r1} : {r1, r0};
    end
  end

endmodule

// File: rtl/ads5404_sync_align.sv
// Finds the ADC sync edge at sample resolution, realigns lane pairs to it,
// checks sync periodicity and keeps saturating overrange/sync-error statistics.
module ads5404_sync_align
  import ads5404_pkg::*;
#(
  parameter int NBITS    = 12,
  parameter int PERIOD_W = 16,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                adc_clk,
  input  logic                user_rst_n,
  input  logic [NBITS-1:0]    da_0,
  input  logic [NBITS-1:0]    da_1,
  input  logic [NBITS-1:0]    db_0,
  input  logic [NBITS-1:0]    db_1,
  input  logic                sync_in_0,
  input  logic                sync_in_1,
  input  logic                ovra_0,
  input  logic                ovra_1,
  input  logic                ovrb_0,
  input  logic                ovrb_1,
  input  logic                arm,
  input  logic [PERIOD_W-1:0] sync_period,
  input  logic                clr_stats,
  output logic [2*NBITS-1:0]  a_out,
  output logic [2*NBITS-1:0]  b_out,
  output logic [1:0]          ovra_out,
  output logic [1:0]          ovrb_out,
  output logic                out_valid,
  output logic                out_sync,
  output logic                phase,
  output logic                locked,
  output logic [CNT_W-1:0]    sync_err_cnt,
  output logic [CNT_W-1:0]    ovra_cnt,
  output logic [CNT_W-1:0]    ovrb_cnt
);

  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic                rst_meta;
  logic                rst_n;
  state_t              state;
  logic                s1_prev;
  logic                edge0;
  logic                edge1;
  logic                accept;
  logic                mismatch;
  logic [PERIOD_W-1:0] word_cnt;
  logic [PERIOD_W-1:0] word_base;
  logic [PERIOD_W-1:0] word_next;
  logic [1:0]          ovra_inc;
  logic [1:0]          ovrb_inc;
  logic [1:0]          sync_w;

  // Reset asserts asynchronously but releases on the clock.
  always_ff @(posedge adc_clk or negedge user_rst_n) begin
    if (!user_rst_n) {rst_meta, rst_n} <= 2'b00;
    else             {rst_meta, rst_n} <= {1'b1, rst_meta};
  end

  // NOTE: every signal here is assigned on every path, so no latch can be inferred.
  always_comb begin
    edge0     = sync_in_0 & ~s1_prev;
    edge1     = sync_in_1 & ~sync_in_0;
    accept    = (edge0 | edge1) & ((state == ARMED) | ((state == LOCKED) & ~arm));
    mismatch  = accept & (state == LOCKED) &
                ((edge1 != phase) | ((sync_period != '0) & (word_cnt != '0)));
    // word_cnt indexes the word starting this cycle; a sync word is index 0.
    word_base = accept ? '0 : word_cnt;
    word_next = ((sync_period != '0) && (word_base >= sync_period - PERIOD_W'(1))) ?
                '0 : word_base + PERIOD_W'(1);
    ovra_inc  = {1'b0, ovra_0} + {1'b0, ovra_1};
    ovrb_inc  = {1'b0, ovrb_0} + {1'b0, ovrb_1};
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= 1'b0;
      word_cnt  <= '0;
      out_valid <= 1'b0;
      s1_prev   <= 1'b0;
    end else begin
      s1_prev   <= sync_in_1;
      out_valid <= (state == LOCKED) & ~arm;
      if (accept) phase <= edge1;
      unique case (state)
        IDLE:    if (arm) state <= ARMED;
        ARMED:   if (accept) begin
                   state    <= LOCKED;
                   word_cnt <= word_next;
                 end
        LOCKED:  if (arm) state <= ARMED;
                 else     word_cnt <= word_next;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err_cnt <= '0;
      ovra_cnt     <= '0;
      ovrb_cnt     <= '0;
    end else if (clr_stats) begin
      sync_err_cnt <= '0;
      ovra_cnt     <= '0;
      ovrb_cnt     <= '0;
    end else begin
      if (mismatch) sync_err_cnt <= CNT_W'(sat_add(32'(sync_err_cnt), 32'd1, CNT_MAX));
      ovra_cnt <= CNT_W'(sat_add(32'(ovra_cnt), 32'(ovra_inc), CNT_MAX));
      ovrb_cnt <= CNT_W'(sat_add(32'(ovrb_cnt), 32'(ovrb_inc), CNT_MAX));
    end
  end

  ads5404_lane_align #(.W(NBITS)) u_da (
    .clk(adc_clk), .rst_n(rst_n), .phase(phase), .x0(da_0), .x1(da_1), .y(a_out)
  );
  ads5404_lane_align #(.W(NBITS)) u_db (
    .clk(adc_clk), .rst_n(rst_n), .phase(phase), .x0(db_0), .x1(db_1), .y(b_out)
  );
  ads5404_lane_align #(.W(1)) u_ovra (
    .clk(adc_clk), .rst_n(rst_n), .phase(phase), .x0(ovra_0), .x1(ovra_1), .y(ovra_out)
  );
  ads5404_lane_align #(.W(1)) u_ovrb (
    .clk(adc_clk), .rst_n(rst_n), .phase(phase), .x0(ovrb_0), .x1(ovrb_1), .y(ovrb_out)
  );
  // Lanes carry accepted edge markers, so bit 0 marks a word starting on the sync sample.
  ads5404_lane_align #(.W(1)) u_sync (
    .clk(adc_clk), .rst_n(rst_n), .phase(phase),
    .x0(accept & edge0), .x1(accept & edge1), .y(sync_w)
  );

  assign locked   = (state == LOCKED);
  assign out_sync = out_valid & (sync_w == 2'b01);

endmodule

// File: tb/tb_ads5404_sync_align.sv
// Directed bench for ads5404_sync_align: alignment in both phases, period checking,
// saturating statistics, re-arm and asynchronous reset.
module tb_ads5404_sync_align;

  localparam int NBITS    = 12;
  localparam int PERIOD_W = 16;
  localparam int CNT_W    = 16;

  logic                adc_clk = 1'b0;
  logic                user_rst_n;
  logic [NBITS-1:0]    da_0, da_1, db_0, db_1;
  logic                sync_in_0, sync_in_1;
  logic                ovra_0, ovra_1, ovrb_0, ovrb_1;
  logic                arm, clr_stats;
  logic [PERIOD_W-1:0] sync_period;

  logic [2*NBITS-1:0]  a_out, b_out;
  logic [1:0]          ovra_out, ovrb_out;
  logic                out_valid, out_sync, phase, locked;
  logic [CNT_W-1:0]    sync_err_cnt, ovra_cnt, ovrb_cnt;

  logic [2*NBITS-1:0]  a_out3, b_out3;
  logic [1:0]          ovra_out3, ovrb_out3;
  logic                out_valid3, out_sync3, phase3, locked3;
  logic [2:0]          sync_err_cnt3, ovra_cnt3, ovrb_cnt3;

  int vectors    = 0;
  int miscompares = 0;
  int k          = 0;
  int ks;

  ads5404_sync_align #(.NBITS(NBITS), .PERIOD_W(PERIOD_W), .CNT_W(CNT_W)) u_dut (
    .adc_clk(adc_clk), .user_rst_n(user_rst_n),
    .da_0(da_0), .da_1(da_1), .db_0(db_0), .db_1(db_1),
    .sync_in_0(sync_in_0), .sync_in_1(sync_in_1),
    .ovra_0(ovra_0), .ovra_1(ovra_1), .ovrb_0(ovrb_0), .ovrb_1(ovrb_1),
    .arm(arm), .sync_period(sync_period), .clr_stats(clr_stats),
    .a_out(a_out), .b_out(b_out), .ovra_out(ovra_out), .ovrb_out(ovrb_out),
    .out_valid(out_valid), .out_sync(out_sync), .phase(phase), .locked(locked),
    .sync_err_cnt(sync_err_cnt), .ovra_cnt(ovra_cnt), .ovrb_cnt(ovrb_cnt)
  );

  // Narrow-counter copy driven by the same stimulus, for saturation checks.
  ads5404_sync_align #(.NBITS(NBITS), .PERIOD_W(PERIOD_W), .CNT_W(3)) u_dut_w3 (
    .adc_clk(adc_clk), .user_rst_n(user_rst_n),
    .da_0(da_0), .da_1(da_1), .db_0(db_0), .db_1(db_1),
    .sync_in_0(sync_in_0), .sync_in_1(sync_in_1),
    .ovra_0(ovra_0), .ovra_1(ovra_1), .ovrb_0(ovrb_0), .ovrb_1(ovrb_1),
    .arm(arm), .sync_period(sync_period), .clr_stats(clr_stats),
    .a_out(a_out3), .b_out(b_out3), .ovra_out(ovra_out3), .ovrb_out(ovrb_out3),
    .out_valid(out_valid3), .out_sync(out_sync3), .phase(phase3), .locked(locked3),
    .sync_err_cnt(sync_err_cnt3), .ovra_cnt(ovra_cnt3), .ovrb_cnt(ovrb_cnt3)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One ADC cycle: ramp data for index k plus the given sync/arm levels.
  task automatic cyc(input logic s0, input logic s1, input logic a);
    da_0 = NBITS'(2 * k);
    da_1 = NBITS'(2 * k + 1);
    db_0 = NBITS'(2 * k + 1000);
    db_1 = NBITS'(2 * k + 1001);
    sync_in_0 = s0;
    sync_in_1 = s1;
    arm = a;
    @(posedge adc_clk);
    #1;
    k++;
  endtask

  task automatic sync_gap(input int gap);
    cyc(1'b1, 1'b1, 1'b0);
    repeat (gap - 1) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    user_rst_n = 1'b0;
    {ovra_0, ovra_1, ovrb_0, ovrb_1} = 4'b0000;
    clr_stats   = 1'b0;
    sync_period = PERIOD_W'(8);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check("reset_a_out", a_out, 0);
    check("reset_valid", out_valid, 0);
    check("reset_locked", locked, 0);
    user_rst_n = 1'b1;
    repeat (4) cyc(1'b0, 1'b0, 1'b0);

    // Phase 0 lock: sync on both lanes at k = 10
    k = 9;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    check("p0_valid_n1", out_valid, 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("p0_a_out", a_out, {12'd21, 12'd20});
    check("p0_b_out", b_out, {12'd1021, 12'd1020});
    check("p0_out_sync", out_sync, 1);
    check("p0_phase", phase, 0);
    check("p0_locked", locked, 1);
    check("p0_valid", out_valid, 1);
    repeat (6) cyc(1'b0, 1'b0, 1'b0);

    // Period 8: five on-time periods, then one sync a word early
    repeat (4) sync_gap(8);
    sync_gap(7);
    check("per_err0", sync_err_cnt, 0);
    check("per_valid", out_valid, 1);
    ks = k;
    cyc(1'b1, 1'b1, 1'b0);
    check("per_err1", sync_err_cnt, 1);
    cyc(1'b0, 1'b0, 1'b0);
    check("early_sync", out_sync, 1);
    check("early_a_out", a_out, {NBITS'(2 * ks + 1), NBITS'(2 * ks)});
    check("early_valid", out_valid, 1);
    repeat (6) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("realign_sync", out_sync, 1);
    check("realign_err", sync_err_cnt, 1);
    check("realign_err_w3", sync_err_cnt3, 1);

    // Re-arm while locked, then relock on a lane-1 sync
    cyc(1'b0, 1'b0, 1'b1);
    check("rearm_valid", out_valid, 0);
    check("rearm_locked", locked, 0);
    k = 10;
    cyc(1'b0, 1'b1, 1'b0);
    check("p1_valid_n1", out_valid, 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("p1_a_out", a_out, {12'd22, 12'd21});
    check("p1_phase", phase, 1);
    check("p1_out_sync", out_sync, 1);
    check("p1_locked", locked, 1);
    check("p1_err_kept", sync_err_cnt, 1);

    // Overrange statistics
    {ovra_0, ovra_1, ovrb_0, ovrb_1} = 4'b1110;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check("ovra_cnt6", ovra_cnt, 6);
    check("ovrb_cnt3", ovrb_cnt, 3);
    check("ovra_cnt6_w3", ovra_cnt3, 6);
    check("ovra_out_p1", ovra_out, 2'b11);
    check("ovrb_out_p1", ovrb_out, 2'b10);
    ovrb_0 = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check("ovra_cnt12", ovra_cnt, 12);
    check("ovra_sat_w3", ovra_cnt3, 7);
    cyc(1'b0, 1'b0, 1'b0);
    check("ovra_hold_w3", ovra_cnt3, 7);
    clr_stats = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    clr_stats = 1'b0;
    check("clr_ovra", ovra_cnt, 0);
    check("clr_ovra_w3", ovra_cnt3, 0);
    check("clr_ovrb", ovrb_cnt, 0);
    check("clr_err", sync_err_cnt, 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("ovra_after_clr", ovra_cnt, 2);
    {ovra_0, ovra_1} = 2'b00;

    // Mid-stream asynchronous reset
    #3;
    user_rst_n = 1'b0;
    #1;
    check("arst_a_out", a_out, 0);
    check("arst_valid", out_valid, 0);
    check("arst_phase", phase, 0);
    check("arst_locked", locked, 0);
    check("arst_ovra_cnt", ovra_cnt, 0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    user_rst_n = 1'b1;
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    sync_gap(3);
    sync_gap(3);
    check("noarm_valid", out_valid, 0);
    check("noarm_locked", locked, 0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("relock_valid", out_valid, 1);
    check("relock_locked", locked, 1);
    check("relock_sync", out_sync, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ads5404_sync_align.md
Name: ads5404_sync_align

Overview:
- Downstream consumer of the ADS5404 DDR capture stage.
- Takes the de-interleaved per-channel sample pairs (Q1/Q2 lanes), sync and overrange flags, all on the ADC output clock.
- Finds the ADC sync rising edge at sample resolution and re-orders lanes so every output word starts on a sync-aligned sample.
- Checks sync periodicity and keeps saturating overrange and sync-error statistics for software.

Parameters:
NBITS, 12, sample width per lane
PERIOD_W, 16, width of sync period config and word counter
CNT_W, 16, width of the overrange and sync-error counters

Ports:
adc_clk  in  1  ADC output clock (clkout of the capture stage)
user_rst_n  in  1  asynchronous active-low reset
da_0, da_1  in  NBITS each  channel A: _0 = earlier sample, _1 = later sample of cycle
db_0, db_1  in  NBITS each  channel B, same ordering
sync_in_0, sync_in_1  in  1 each  ADC sync, same lane ordering
ovra_0, ovra_1, ovrb_0, ovrb_1  in  1 each  overrange flags, same lane ordering
arm  in  1  pulse: (re)acquire alignment
sync_period  in  PERIOD_W  expected words between syncs; 0 = no period check
clr_stats  in  1  sync clear of all counters
a_out, b_out  out  2*NBITS each  aligned word {later, earlier}
ovra_out, ovrb_out  out  2 each  overrange aligned with data, [0] = earlier
out_valid  out  1  aligned word valid
out_sync  out  1  word whose sample 0 is the sync sample
phase  out  1  lane of captured sync edge (0 = lane 0)
locked  out  1  state == LOCKED
sync_err_cnt, ovra_cnt, ovrb_cnt  out  CNT_W each  saturating counters

Behaviour:
- Serial sample order: x_0[n], x_1[n], x_0[n+1], ...
- Reset (async assert, sync deassert internally): every output and register is 0; state = IDLE.
- Edge detect uses s1_prev, the registered sync_in_1 of the previous cycle.
  - edge0 = sync_in_0 & ~s1_prev
  - edge1 = sync_in_1 & ~sync_in_0
  - The two are mutually exclusive by construction.
- Stage 1 (r1) registers all inputs unconditionally.
- Output register loads at the end of cycle n+1:
  - phase 0: {r1.x_1, r1.x_0}
  - phase 1: {in.x_0, r1.x_1}
  - ovr bits and sync are formed the same way.
  - Latency is 2 cycles from the cycle holding the word's earliest sample, for both phases.
- States:
  - IDLE: out_valid = 0. arm → ARMED.
  - ARMED: out_valid = 0. On edge0/edge1: latch phase, word_cnt = 0, → LOCKED. The first valid word carries the sync sample with out_sync = 1.
  - LOCKED: out_valid = 1 every cycle. word_cnt increments per word; when sync_period != 0 it wraps to 0 at sync_period−1.
- Sync check in LOCKED:
  - A sync edge is expected when the word it starts has word_cnt == 0.
  - Mismatch = edge with a different phase, or (sync_period != 0 and word_cnt ≠ 0).
  - On mismatch: sync_err_cnt +1 (saturating), phase re-latched, word_cnt = 0 (realign). out_valid stays 1.
  - out_sync asserts on every accepted sync word, whether matching or realigned.
- arm in LOCKED → ARMED; out_valid drops the next cycle.
- arm in ARMED: no effect.
- ovra_cnt/ovrb_cnt add popcount of the two raw lane flags (0..2) every cycle, in all states, and saturate at 2^CNT_W−1. Adding 2 at max−1 gives max.
- clr_stats and an increment in the same cycle: clear wins (result 0).
- sync_period changes take effect on the next wrap comparison; no retroactive error.

Decomposition:
- Shared package ads5404_pkg:
  - state enum {IDLE, ARMED, LOCKED}
  - CNT_W default
  - saturating-add function
- One natural sub-module: ads5404_lane_align, the per-signal 2-lane phase mux plus delay register. Instantiate it for da, db, ovra, ovrb, sync.
- Control FSM and counters stay in the top level.

Test Plan:
1. Assert user_rst_n = 0 mid-stream → all outputs 0 immediately; after release, out_valid = 0 until arm plus a sync edge.
2. Phase 0: drive ramp da_0 = 2k, da_1 = 2k+1; arm; sync_in_0 rises at cycle n (k = 10). Required at n+2: a_out = {21, 20}, out_sync = 1, phase = 0, locked = 1; out_valid holds 1 thereafter.
3. Phase 1: same ramp; sync_in_1 rises with sync_in_0 = 0 at k = 10. Required at n+2: a_out = {22, 21}, phase = 1, out_sync = 1.
4. Period check: sync_period = 8, syncs every 8 words for 5 periods → sync_err_cnt = 0. Then one sync arrives 1 word early → sync_err_cnt = 1, out_sync on the early word, next check expects +8 from it.
5. Overrange: ovra_0 = ovra_1 = 1 for 3 cycles → ovra_cnt = 6. With CNT_W = 3, holding the flags high gives ovra_cnt = 7 and it stays 7. clr_stats together with the flags → 0.
6. Re-arm while LOCKED → out_valid low the next cycle; then a phase-1 sync → relock with phase = 1 and sync_err_cnt unchanged.
